// File: rtl/multichannel_enable_delay_if.sv
// Enable-delay bus: raw enables and packed per-channel delays in,
// delayed enables and countdown status out.
interface multichannel_enable_delay_if #(
  parameter int N_CHANNELS    = 4,
  parameter int COUNTER_WIDTH = 16
);
  logic [N_CHANNELS-1:0]               enable;
  logic [N_CHANNELS*COUNTER_WIDTH-1:0] rise_delay;
  logic [N_CHANNELS*COUNTER_WIDTH-1:0] fall_delay;
  logic [N_CHANNELS-1:0]               delayed_enable;
  logic [N_CHANNELS-1:0]               busy;

  modport master (
    output enable, rise_delay, fall_delay,
    input  delayed_enable, busy
  );

  modport slave (
    input  enable, rise_delay, fall_delay,
    output delayed_enable, busy
  );
endinterface

// File: rtl/multichannel_enable_delay.sv
// N independent enable channels, each with programmable turn-on and turn-off
// delays; pulses no longer than the applicable delay are swallowed.
module multichannel_enable_delay #(
  parameter int N_CHANNELS    = 4,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  multichannel_enable_delay_if.slave bus
);

  localparam logic [1:0] S_OFF       = 2'd0;
  localparam logic [1:0] S_RISE_WAIT = 2'd1;
  localparam logic [1:0] S_ON        = 2'd2;
  localparam logic [1:0] S_FALL_WAIT = 2'd3;

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  logic [1:0]               state_q [N_CHANNELS];
  logic [1:0]               state_d [N_CHANNELS];
  logic [COUNTER_WIDTH-1:0] count_q [N_CHANNELS];
  logic [COUNTER_WIDTH-1:0] count_d [N_CHANNELS];
  logic [N_CHANNELS-1:0]    out_q, out_d;
  logic [N_CHANNELS-1:0]    busy_q, busy_d;

  always_comb begin
    out_d  = out_q;
    busy_d = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      logic [COUNTER_WIDTH-1:0] rd, fd;
      rd         = bus.rise_delay[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      fd         = bus.fall_delay[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      case (state_q[i])
        S_OFF: begin
          if (bus.enable[i]) begin
            if (rd == '0) begin
              state_d[i] = S_ON;
              out_d[i]   = 1'b1;
            end else begin
              state_d[i] = S_RISE_WAIT;
              count_d[i] = rd;
            end
          end
        end
        S_RISE_WAIT: begin
          if (!bus.enable[i]) begin
            state_d[i] = S_OFF;
          end else if (count_q[i] == ONE) begin
            state_d[i] = S_ON;
            out_d[i]   = 1'b1;
          end else begin
            count_d[i] = count_q[i] - ONE;
          end
        end
        S_ON: begin
          if (!bus.enable[i]) begin
            if (fd == '0) begin
              state_d[i] = S_OFF;
              out_d[i]   = 1'b0;
            end else begin
              state_d[i] = S_FALL_WAIT;
              count_d[i] = fd;
            end
          end
        end
        default: begin
          // FALL_WAIT: a returning enable cancels the turn-off, output never dips.
          if (bus.enable[i]) begin
            state_d[i] = S_ON;
          end else if (count_q[i] == ONE) begin
            state_d[i] = S_OFF;
            out_d[i]   = 1'b0;
          end else begin
            count_d[i] = count_q[i] - ONE;
          end
        end
      endcase
      busy_d[i] = (state_d[i] == S_RISE_WAIT) || (state_d[i] == S_FALL_WAIT);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        state_q[i] <= S_OFF;
        count_q[i] <= '0;
      end
      out_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      out_q  <= out_d;
      busy_q <= busy_d;
    end
  end

  assign bus.delayed_enable = out_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multichannel_enable_delay.sv
// Directed and randomized checks of multichannel_enable_delay against a
// deadline-based reference model.
module tb_multichannel_enable_delay;
  localparam int N  = 4;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multichannel_enable_delay_if #(.N_CHANNELS(N), .COUNTER_WIDTH(CW)) bus ();
  multichannel_enable_delay_if #(.N_CHANNELS(1), .COUNTER_WIDTH(4))  sbus ();

  multichannel_enable_delay #(.N_CHANNELS(N), .COUNTER_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  multichannel_enable_delay #(.N_CHANNELS(1), .COUNTER_WIDTH(4)) dut_small (
    .clock(clock), .reset(reset), .bus(sbus)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: each channel has an output level and, when a change is
  // pending, the absolute cycle number at which it takes effect.
  bit     m_out  [N];
  bit     m_pend [N];
  longint m_dl   [N];
  longint cyc = 0;

  int first_hi, first_lo, hi_cnt, busy_cnt, glitch_hi, drops;
  logic b6, b7;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setd(input int c, input int r, input int f);
    bus.rise_delay[c*CW +: CW] = CW'(r);
    bus.fall_delay[c*CW +: CW] = CW'(f);
  endtask

  task automatic tick();
    logic [N-1:0] ed, eb;
    bit e;
    longint d;
    @(posedge clock);
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (!reset) begin
        m_out[c]  = 0;
        m_pend[c] = 0;
      end else begin
        e = bus.enable[c];
        if (!m_pend[c]) begin
          if (e != m_out[c]) begin
            d = e ? longint'(bus.rise_delay[c*CW +: CW]) : longint'(bus.fall_delay[c*CW +: CW]);
            if (d == 0) m_out[c] = e;
            else begin
              m_pend[c] = 1;
              m_dl[c]   = cyc + d;
            end
          end
        end else if (e == m_out[c]) begin
          m_pend[c] = 0;
        end else if (cyc == m_dl[c]) begin
          m_out[c]  = e;
          m_pend[c] = 0;
        end
      end
    end
    @(negedge clock);
    for (int c = 0; c < N; c++) begin
      ed[c] = m_out[c];
      eb[c] = m_pend[c];
    end
    chk("model_delayed_enable", 64'(bus.delayed_enable), 64'(ed));
    chk("model_busy", 64'(bus.busy), 64'(eb));
  endtask

  initial begin
    bus.enable      = '1;
    bus.rise_delay  = '0;
    bus.fall_delay  = '0;
    sbus.enable     = '0;
    sbus.rise_delay = '0;
    sbus.fall_delay = '0;
    @(negedge clock);

    // Reset held with all enables high
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_delayed_enable", 64'(bus.delayed_enable), 64'h0);
      chk("reset_busy", 64'(bus.busy), 64'h0);
    end
    reset = 1'b1;
    tick();
    chk("post_reset_all_on", 64'(bus.delayed_enable), 64'hF);

    bus.enable = '0;
    repeat (3) tick();

    // Channel 0: rise 10, fall 4, 50-cycle input pulse
    setd(0, 10, 4);
    first_hi = 0; first_lo = 0; hi_cnt = 0; busy_cnt = 0;
    for (int i = 1; i <= 70; i++) begin
      bus.enable[0] = (i <= 50);
      tick();
      if (bus.delayed_enable[0]) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = i;
      end else if (first_hi != 0 && first_lo == 0) first_lo = i;
      if (bus.busy[0]) busy_cnt++;
    end
    chk("rise_latency", 64'(first_hi), 64'd11);
    chk("fall_index", 64'(first_lo), 64'd55);
    chk("pulse_width", 64'(hi_cnt), 64'd44);
    chk("busy_cycles", 64'(busy_cnt), 64'd14);

    // Channel 1: short high pulse swallowed
    setd(1, 8, 0);
    glitch_hi = 0; b6 = 1'b0; b7 = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      bus.enable[1] = (i <= 6);
      tick();
      if (bus.delayed_enable[1]) glitch_hi++;
      if (i == 6) b6 = bus.busy[1];
      if (i == 7) b7 = bus.busy[1];
    end
    chk("glitch_output", 64'(glitch_hi), 64'd0);
    chk("glitch_busy_before_abort", 64'(b6), 64'd1);
    chk("glitch_busy_after_abort", 64'(b7), 64'd0);

    // Channel 1: short low gap swallowed
    setd(1, 0, 8);
    bus.enable[1] = 1'b1;
    repeat (2) tick();
    drops = 0;
    for (int i = 1; i <= 14; i++) begin
      bus.enable[1] = (i > 3);
      tick();
      if (!bus.delayed_enable[1]) drops++;
    end
    chk("gap_output_drops", 64'(drops), 64'd0);
    bus.enable[1] = 1'b0;
    repeat (12) tick();
    chk("gap_final_off", 64'(bus.delayed_enable[1]), 64'd0);

    // Channel 2: delay changed mid-countdown
    setd(2, 20, 0);
    first_hi = 0;
    for (int i = 1; i <= 30; i++) begin
      bus.enable[2] = 1'b1;
      if (i == 6) setd(2, 3, 0);
      tick();
      if (bus.delayed_enable[2] && first_hi == 0) first_hi = i;
    end
    chk("midchange_latency", 64'(first_hi), 64'd21);
    bus.enable[2] = 1'b0;
    repeat (2) tick();
    first_hi = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.enable[2] = 1'b1;
      tick();
      if (bus.delayed_enable[2] && first_hi == 0) first_hi = i;
    end
    chk("new_delay_latency", 64'(first_hi), 64'd4);

    // All channels: staggered turn-on, then reset mid-countdown
    bus.enable = '0;
    repeat (3) tick();
    setd(0, 0, 0); setd(1, 1, 0); setd(2, 2, 0); setd(3, 3, 0);
    bus.enable = '1;
    tick(); chk("stagger_1", 64'(bus.delayed_enable), 64'h1);
    tick(); chk("stagger_2", 64'(bus.delayed_enable), 64'h3);
    tick(); chk("stagger_3", 64'(bus.delayed_enable), 64'h7);
    tick(); chk("stagger_4", 64'(bus.delayed_enable), 64'hF);
    bus.enable = '0;
    tick(); chk("stagger_off", 64'(bus.delayed_enable), 64'h0);
    tick();
    bus.enable = '1;
    tick(); tick();
    chk("pre_reset_out", 64'(bus.delayed_enable), 64'h3);
    chk("pre_reset_busy", 64'(bus.busy), 64'hC);
    reset = 1'b0;
    tick();
    chk("midcount_reset_out", 64'(bus.delayed_enable), 64'h0);
    chk("midcount_reset_busy", 64'(bus.busy), 64'h0);
    reset = 1'b1;
    bus.enable = '0;
    tick();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) bus.enable[c] = ~bus.enable[c];
        if ($urandom_range(0, 7) == 0)
          setd(c, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      end
      reset = ($urandom_range(0, 60) != 0);
      tick();
    end
    reset = 1'b1;

    // Narrow instance: maximum delay without wrap
    sbus.rise_delay = 4'd15;
    sbus.enable     = 1'b1;
    first_hi = 0; busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sbus.delayed_enable[0] && first_hi == 0) first_hi = i;
      if (sbus.busy[0]) busy_cnt++;
    end
    chk("max_delay_latency", 64'(first_hi), 64'd16);
    chk("max_delay_busy", 64'(busy_cnt), 64'd15);
    chk("max_delay_held", 64'(sbus.delayed_enable), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
